// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port 8K x 16 synchronous RAM between a CPU port (A) and a loader port (B).
// Grants are combinational; read data returns one cycle later to the port that was granted.
module mem_arbiter #(
  parameter bit RR_EN = 1'b1,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [15:0]   a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [15:0]   a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [15:0]   b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [15:0]   b_rdata,
  input  logic          b_lock,
  output logic          locked,
  output logic [AW-1:0] mem_address,
  output logic [15:0]   mem_dataW,
  output logic          mem_load,
  input  logic [15:0]   mem_dataR
);
  typedef enum logic {RR, LOCKED} state_t;
  state_t state_q, state_d;
  logic ptr_q, ptr_d;
  logic a_rv_q, a_rv_d, b_rv_q, b_rv_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RR;
      ptr_q   <= 1'b0;
      a_rv_q  <= 1'b0;
      b_rv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      a_rv_q  <= a_rv_d;
      b_rv_q  <= b_rv_d;
    end
  end
  // ptr = 0 favours A, ptr = 1 favours B when both request
  always_comb begin
    a_gnt       = !reset && state_q == RR && a_req && (!b_req || !RR_EN || !ptr_q);
    b_gnt       = !reset && b_req && (state_q == LOCKED || !a_req || (RR_EN && ptr_q));
    state_d     = b_lock ? LOCKED : RR;
    ptr_d       = (state_q == LOCKED && !b_lock) ? 1'b0 : a_gnt ? 1'b1 : b_gnt ? 1'b0 : ptr_q;
    a_rv_d      = a_gnt && !a_we;
    b_rv_d      = b_gnt && !b_we;
    mem_address = a_gnt ? a_addr : b_gnt ? b_addr : '0;
    mem_dataW   = a_gnt ? a_wdata : b_gnt ? b_wdata : '0;
    mem_load    = (a_gnt && a_we) || (b_gnt && b_we);
  end
  assign locked   = state_q == LOCKED;
  assign a_rvalid = a_rv_q && !reset;
  assign b_rvalid = b_rv_q && !reset;
  assign a_rdata  = mem_dataR;
  assign b_rdata  = mem_dataR;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed tests for mem_arbiter, round-robin instance plus a fixed-priority instance.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we, b_lock;
  logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid, locked, mem_load;
  logic [15:0] a_rdata, b_rdata, mem_address, mem_dataW, mem_dataR;
  logic        f_a_gnt, f_a_rvalid, f_b_gnt, f_b_rvalid, f_locked, f_mem_load;
  logic [15:0] f_a_rdata, f_b_rdata, f_mem_address, f_mem_dataW, f_mem_dataR;
  logic [15:0] mem0 [0:8191];
  logic [15:0] mem1 [0:8191];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.RR_EN(1'b1), .AW(16)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .b_lock(b_lock), .locked(locked),
    .mem_address(mem_address), .mem_dataW(mem_dataW), .mem_load(mem_load), .mem_dataR(mem_dataR)
  );

  mem_arbiter #(.RR_EN(1'b0), .AW(16)) dut_fp (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(f_a_gnt), .a_rvalid(f_a_rvalid), .a_rdata(f_a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(f_b_gnt), .b_rvalid(f_b_rvalid), .b_rdata(f_b_rdata),
    .b_lock(b_lock), .locked(f_locked),
    .mem_address(f_mem_address), .mem_dataW(f_mem_dataW), .mem_load(f_mem_load), .mem_dataR(f_mem_dataR)
  );

  always_ff @(posedge clk) begin
    if (mem_load) mem0[mem_address[12:0]] <= mem_dataW;
    mem_dataR <= mem0[mem_address[12:0]];
    if (f_mem_load) mem1[f_mem_address[12:0]] <= f_mem_dataW;
    f_mem_dataR <= mem1[f_mem_address[12:0]];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
  endtask

  task automatic test_reset();
    reset = 1; b_lock = 0;
    a_req = 1; a_we = 1; a_addr = 16'h0033; a_wdata = 16'h5555;
    b_req = 1; b_we = 1; b_addr = 16'h0044; b_wdata = 16'h6666;
    step(); step();
    @(negedge clk);
    n_chk++; if ({a_gnt, b_gnt} !== 2'b00) begin n_fail++; $display("FAIL rst_gnt got %b exp 00", {a_gnt, b_gnt}); end
    n_chk++; if ({a_rvalid, b_rvalid, locked} !== 3'b000) begin n_fail++; $display("FAIL rst_rvalid_locked got %b exp 000", {a_rvalid, b_rvalid, locked}); end
    n_chk++; if ({mem_load, mem_address, mem_dataW} !== 33'd0) begin n_fail++; $display("FAIL rst_mem got load=%b addr=%h data=%h exp 0/0/0", mem_load, mem_address, mem_dataW); end
    step();
    reset = 0; idle();
  endtask

  task automatic test_basic_read();
    b_req = 1; b_we = 1; b_addr = 5; b_wdata = 16'h1234;
    @(negedge clk);
    n_chk++; if ({b_gnt, mem_load, mem_address} !== {2'b11, 16'd5}) begin n_fail++; $display("FAIL t1_bwrite got gnt=%b load=%b addr=%h exp 1/1/0005", b_gnt, mem_load, mem_address); end
    step();
    idle(); a_req = 1; a_addr = 5;
    @(negedge clk);
    n_chk++; if ({a_gnt, b_gnt, b_rvalid} !== 3'b100) begin n_fail++; $display("FAIL t1_agnt got a_gnt,b_gnt,b_rvalid=%b exp 100", {a_gnt, b_gnt, b_rvalid}); end
    step();
    idle();
    @(negedge clk);
    n_chk++; if ({a_rvalid, b_rvalid} !== 2'b10) begin n_fail++; $display("FAIL t1_rvalid got %b exp 10", {a_rvalid, b_rvalid}); end
    n_chk++; if (a_rdata !== 16'h1234) begin n_fail++; $display("FAIL t1_rdata got %h exp 1234", a_rdata); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_a;
    exp_a = 4'b0101;
    b_req = 1; b_we = 1; b_addr = 1; b_wdata = 16'h1111;
    step();
    b_addr = 2; b_wdata = 16'h2222;
    step();
    idle();
    a_req = 1; a_addr = 1; b_req = 1; b_addr = 2;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) idle();
      @(negedge clk);
      if (i < 4) begin
        n_chk++; if ({a_gnt, b_gnt} !== {exp_a[i], !exp_a[i]}) begin n_fail++; $display("FAIL t2_gnt[%0d] got %b exp %b", i, {a_gnt, b_gnt}, {exp_a[i], !exp_a[i]}); end
      end
      if (i > 0) begin
        n_chk++; if ({a_rvalid, b_rvalid} !== {exp_a[i-1], !exp_a[i-1]}) begin n_fail++; $display("FAIL t2_rvalid[%0d] got %b exp %b", i, {a_rvalid, b_rvalid}, {exp_a[i-1], !exp_a[i-1]}); end
        n_chk++; if (mem_dataR !== (exp_a[i-1] ? 16'h1111 : 16'h2222) || a_rdata !== mem_dataR) begin n_fail++; $display("FAIL t2_rdata[%0d] got %h exp %h", i, a_rdata, exp_a[i-1] ? 16'h1111 : 16'h2222); end
      end
      step();
    end
  endtask

  task automatic test_fixed_priority();
    a_req = 1; a_addr = 3; b_req = 1; b_addr = 4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++; if ({f_a_gnt, f_b_gnt} !== 2'b10) begin n_fail++; $display("FAIL t3_fp_gnt[%0d] got %b exp 10", i, {f_a_gnt, f_b_gnt}); end
      step();
    end
    a_req = 0;
    @(negedge clk);
    n_chk++; if ({f_a_gnt, f_b_gnt, f_mem_address} !== {2'b01, 16'd4}) begin n_fail++; $display("FAIL t3_fp_b got gnt=%b addr=%h exp 01/0004", {f_a_gnt, f_b_gnt}, f_mem_address); end
    step();
    idle();
    step();
  endtask

  task automatic test_lock();
    a_req = 1; a_addr = 1; b_lock = 1;
    @(negedge clk);
    n_chk++; if ({locked, a_gnt} !== 2'b01) begin n_fail++; $display("FAIL t4_entry got locked,a_gnt=%b exp 01", {locked, a_gnt}); end
    step();
    b_req = 1; b_we = 1; b_addr = 0; b_wdata = 16'h00AA;
    @(negedge clk);
    n_chk++; if ({locked, a_gnt, b_gnt, mem_load} !== 4'b1011) begin n_fail++; $display("FAIL t4_lock1 got %b exp 1011", {locked, a_gnt, b_gnt, mem_load}); end
    n_chk++; if ({a_rvalid, a_rdata} !== {1'b1, 16'h1111}) begin n_fail++; $display("FAIL t4_pre_lock_read got v=%b d=%h exp 1/1111", a_rvalid, a_rdata); end
    step();
    b_addr = 1; b_wdata = 16'h00BB;
    @(negedge clk);
    n_chk++; if ({locked, a_gnt, b_gnt, a_rvalid} !== 4'b1010) begin n_fail++; $display("FAIL t4_lock2 got %b exp 1010", {locked, a_gnt, b_gnt, a_rvalid}); end
    step();
    b_req = 0; b_we = 0; b_lock = 0;
    @(negedge clk);
    n_chk++; if ({locked, a_gnt, b_gnt} !== 3'b100) begin n_fail++; $display("FAIL t4_lock3 got %b exp 100", {locked, a_gnt, b_gnt}); end
    step();
    b_req = 1; b_addr = 2;
    @(negedge clk);
    n_chk++; if ({locked, a_gnt, b_gnt} !== 3'b010) begin n_fail++; $display("FAIL t4_exit got %b exp 010", {locked, a_gnt, b_gnt}); end
    step();
    idle();
    @(negedge clk);
    n_chk++; if ({a_rvalid, a_rdata} !== {1'b1, 16'h00BB}) begin n_fail++; $display("FAIL t4_read got v=%b d=%h exp 1/00bb", a_rvalid, a_rdata); end
    step();
  endtask

  task automatic test_reset_mid_read();
    a_req = 1; a_addr = 2;
    @(negedge clk);
    n_chk++; if (a_gnt !== 1'b1) begin n_fail++; $display("FAIL t5_grant got %b exp 1", a_gnt); end
    step();
    reset = 1; a_req = 1; a_we = 1;
    @(negedge clk);
    n_chk++; if ({a_rvalid, mem_load, a_gnt} !== 3'b000) begin n_fail++; $display("FAIL t5_in_reset got rvalid,load,gnt=%b exp 000", {a_rvalid, mem_load, a_gnt}); end
    step();
    reset = 0; a_we = 0; a_addr = 1; b_req = 1; b_addr = 2;
    @(negedge clk);
    n_chk++; if ({a_rvalid, a_gnt, b_gnt} !== 3'b010) begin n_fail++; $display("FAIL t5_after got rvalid,a_gnt,b_gnt=%b exp 010", {a_rvalid, a_gnt, b_gnt}); end
    step();
    idle();
    step();
  endtask

  task automatic test_top_address();
    b_req = 1; b_we = 1; b_addr = 16'd8191; b_wdata = 16'hFFFF;
    @(negedge clk);
    n_chk++; if ({b_gnt, mem_load, mem_address, mem_dataW} !== {2'b11, 16'd8191, 16'hFFFF}) begin n_fail++; $display("FAIL t6_write got gnt=%b load=%b addr=%h data=%h exp 1/1/1fff/ffff", b_gnt, mem_load, mem_address, mem_dataW); end
    step();
    idle();
    @(negedge clk);
    n_chk++; if ({mem_load, b_rvalid} !== 2'b00) begin n_fail++; $display("FAIL t6_after_write got load,b_rvalid=%b exp 00", {mem_load, b_rvalid}); end
    step();
    a_req = 1; a_addr = 16'd8191;
    @(negedge clk);
    n_chk++; if ({a_gnt, mem_load} !== 2'b10) begin n_fail++; $display("FAIL t6_read_gnt got %b exp 10", {a_gnt, mem_load}); end
    step();
    idle();
    @(negedge clk);
    n_chk++; if ({a_rvalid, a_rdata} !== {1'b1, 16'hFFFF}) begin n_fail++; $display("FAIL t6_read got v=%b d=%h exp 1/ffff", a_rvalid, a_rdata); end
    step();
  endtask

  initial begin
    idle();
    test_reset();
    test_basic_read();
    step();
    test_round_robin();
    test_fixed_priority();
    test_lock();
    test_reset_mid_read();
    test_top_address();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port 8K x 16 synchronous RAM (registered read, 1-cycle latency; write on clock edge when load=1) between two requesters.
- Port A: Hack CPU data port. Port B: debug/program-loader port (UART loader).
- One memory access is granted per cycle, using round-robin (or fixed-priority) arbitration. Read data is routed back to the requester that issued the read.
- Port B can take an exclusive lock so a program can be loaded while the CPU is held off.

Parameters:
- RR_EN, 1, 1 = round-robin between A and B; 0 = fixed priority with A always winning.
- AW, 16, address width on all ports. The memory uses address[12:0].

Ports:
- clk  in  1  system clock; all logic runs on its rising edge.
- reset  in  1  synchronous, active-high reset.
- a_req  in  1  port A access request; held high until a_gnt.
- a_we  in  1  port A write enable (1 = write, 0 = read).
- a_addr  in  AW  port A address.
- a_wdata  in  16  port A write data.
- a_gnt  out  1  port A granted this cycle (combinational).
- a_rvalid  out  1  a_rdata is valid (registered).
- a_rdata  out  16  port A read data.
- b_req, b_we, b_addr, b_wdata  in  1/1/AW/16  port B request signals, same rules as port A.
- b_gnt, b_rvalid, b_rdata  out  1/1/16  port B responses, same rules as port A.
- b_lock  in  1  port B requests exclusive ownership of the memory.
- locked  out  1  high while in state LOCKED.
- mem_address  out  AW  to memory address input.
- mem_dataW  out  16  to memory write-data input.
- mem_load  out  1  to memory load (write strobe).
- mem_dataR  in  16  from memory registered read data.

Behaviour:
- Reset: clk rising edge with reset=1 sets the following.
  - state = RR; priority pointer ptr = A.
  - a_rvalid = 0, b_rvalid = 0, and the internal read tag is cleared.
  - While reset is high: a_gnt = 0, b_gnt = 0, mem_load = 0, mem_address = 0, mem_dataW = 0.
  - A reset in the middle of a read discards the pending rvalid; no response is delivered.
- Grant logic: combinational, in the same cycle as the request.
  - RR state, only one port requesting: that port is granted.
  - RR state, both ports requesting, RR_EN=1: the port selected by ptr wins.
  - RR state, both ports requesting, RR_EN=0: A wins.
  - LOCKED state: only B can be granted; a_gnt = 0.
  - a_gnt and b_gnt are never high together.
- Pointer update: on a grant, ptr moves to the other port (A granted -> ptr = B; B granted -> ptr = A). With no grant, ptr holds.
- Memory drive:
  - mem_address and mem_dataW come from the granted port; with no grant they are 0.
  - mem_load = gnt & we of the granted port.
  - With no grant, mem_load = 0.
- Read return:
  - A read granted in cycle N gives x_rvalid = 1 for exactly one cycle, in cycle N+1, with x_rdata = mem_dataR.
  - Only the port that was granted in cycle N sees rvalid.
  - A write never produces rvalid.
  - Back-to-back grants in cycles N and N+1 produce rvalid in N+1 and N+2 with no bubble.
  - rdata is don't-care when rvalid = 0. Drive it as mem_dataR.
- Lock state machine (states RR and LOCKED):
  - RR -> LOCKED on a rising edge with b_lock = 1. Arbitration in that same cycle is still normal RR. locked goes high the following cycle.
  - LOCKED -> RR on a rising edge with b_lock = 0, with ptr forced to A so the CPU is served first.
  - A pending A request during LOCKED stays un-granted (A holds a_req).
  - A read granted to A in the cycle before LOCKED is entered still returns a_rvalid normally.
- Requesters must keep req/we/addr/wdata stable until gnt. Changing them before gnt is undefined.
- No address range checking. Aliasing above 8191 is the memory's behaviour.

Test Plan:
1. Reset, then A reads address 5 after B has written 0x1234 there. Required: a_gnt in the same cycle, a_rvalid one cycle later with a_rdata = 0x1234, b_rvalid = 0.
2. RR_EN=1, A and B both holding req for 4 cycles, reads of addr 1/2. Required: grant order A, B, A, B; each rvalid goes to the matching port one cycle after its grant, with no bubble.
3. RR_EN=0, both ports requesting continuously. Required: A is granted every cycle and b_gnt stays 0. When A drops req, B is granted in that same cycle.
4. b_lock=1 while A keeps requesting; B writes 0x00AA, 0x00BB to addr 0..1, then b_lock=0. Required: locked = 1 from the next cycle; a_gnt = 0 for the whole LOCKED period; after exit, A is granted first; an A read of addr 1 returns 0x00BB.
5. Reset asserted the cycle after an A read grant. Required: a_rvalid stays 0, mem_load = 0, and after release the first grant with both ports requesting goes to A.
6. B write with b_we=1, addr 8191, data 0xFFFF. Required: mem_load = 1 for exactly one cycle and b_rvalid = 0; a following read of 8191 returns 0xFFFF.
